// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a two-entry skid buffer and a flush port.
// Define PIPE_STAGE_SKID_PERF_EN to build the saturating stall/flush counters.
module pipe_stage_skid #(
  parameter int unsigned             CTRL_W      = 8,
  parameter int unsigned             DATA_W      = 32,
  parameter logic [CTRL_W-1:0]       CTRL_BUBBLE = '0,
  parameter bit                      CLEAR_DATA  = 1'b0,
  parameter int unsigned             CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  // Handshake outputs decode only registered state.
  assign in_ready  = (state_q != SKID);
  assign out_valid = (state_q != EMPTY);
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = CTRL_BUBBLE;
      skid_ctrl_d = CTRL_BUBBLE;
      if (CLEAR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      unique case (1'b1)
        (state_q == EMPTY): begin
          if (in_valid) begin
            state_d     = FULL;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        (state_q == FULL): begin
          if (out_ready && in_valid) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (out_ready) begin
            state_d     = EMPTY;
            main_ctrl_d = CTRL_BUBBLE;
          end else if (in_valid) begin
            state_d     = SKID;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end
        end
        (state_q == SKID): begin
          if (out_ready) begin
            state_d     = FULL;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = CTRL_BUBBLE;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_ctrl_d = CTRL_BUBBLE;
          skid_ctrl_d = CTRL_BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= CTRL_BUBBLE;
      main_data_q <= '0;
      skid_ctrl_q <= CTRL_BUBBLE;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: two instances differing in
// CLEAR_DATA and counter width, driven by identical stimulus.
module tb_pipe_stage_skid;

  localparam logic [7:0] BUB = 8'h5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [7:0]  in_ctrl;
  logic [31:0] in_data;
  logic        out_ready;

  logic        rdy0, vld0, rdy1, vld1;
  logic [7:0]  ctl0, ctl1;
  logic [31:0] dat0, dat1;
  logic [3:0]  stc0, flc0;
  logic [15:0] stc1, flc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .CTRL_W(8), .DATA_W(32), .CTRL_BUBBLE(BUB),
    .CLEAR_DATA(1'b0), .CNT_W(4)
  ) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(vld0), .out_ready(out_ready),
    .out_ctrl(ctl0), .out_data(dat0),
    .stall_cnt(stc0), .flush_cnt(flc0)
  );

  pipe_stage_skid #(
    .CTRL_W(8), .DATA_W(32), .CTRL_BUBBLE(BUB),
    .CLEAR_DATA(1'b1), .CNT_W(16)
  ) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(vld1), .out_ready(out_ready),
    .out_ctrl(ctl1), .out_data(dat1),
    .stall_cnt(stc1), .flush_cnt(flc1)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic v, input logic [7:0] c,
                      input logic [31:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  function automatic logic [15:0] perf(input int v);
`ifdef PIPE_STAGE_SKID_PERF_EN
    return 16'(v);
`else
    return 16'(v * 0);
`endif
  endfunction

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    push(1'b0, 8'h00, 32'h0);
    #12;
    rst = 1'b0;
    check("rst_valid", vld0, 0);
    check("rst_ready", rdy0, 1);
    check("rst_ctrl", ctl0, BUB);
    check("rst_data", dat0, 0);
    check("rst_stall", stc0, 0);
    check("rst_flush", flc0, 0);

    // load one entry, then async reset mid-cycle
    push(1'b1, 8'h11, 32'hDEAD);
    cyc();
    check("load_valid", vld0, 1);
    check("load_data", dat0, 32'hDEAD);
    push(1'b0, 8'h00, 32'h0);
    #3 rst = 1'b1;
    #1;
    check("arst_valid", vld0, 0);
    check("arst_ready", rdy0, 1);
    check("arst_ctrl", ctl0, BUB);
    check("arst_data", dat0, 0);
    rst = 1'b0;
    cyc();

    // streaming 1..4
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push(1'b1, 8'(i), 32'(i));
      cyc();
      check("strm_valid", vld0, 1);
      check("strm_data", dat0, 64'(i));
      check("strm_ctrl", ctl0, 64'(i));
    end
    push(1'b0, 8'h00, 32'h0);
    cyc();
    check("drain_valid", vld0, 0);
    check("drain_ctrl", ctl0, BUB);
    check("drain_hold", dat0, 4);

    // backpressure: A, B into skid, C held upstream
    out_ready = 1'b0;
    push(1'b1, 8'h0A, 32'hA0);
    cyc();
    check("bp_a_ready", rdy0, 1);
    push(1'b1, 8'h0B, 32'hB0);
    cyc();
    check("bp_skid_ready", rdy0, 0);
    check("bp_skid_data", dat0, 32'hA0);
    push(1'b1, 8'h0C, 32'hC0);
    cyc();
    check("bp_hold_data", dat0, 32'hA0);
    check("bp_hold_ready", rdy0, 0);
    out_ready = 1'b1;
    cyc();
    check("bp_b_data", dat0, 32'hB0);
    check("bp_b_ctrl", ctl0, 8'h0B);
    check("bp_b_ready", rdy0, 1);
    cyc();
    check("bp_c_data", dat0, 32'hC0);
    check("bp_c_valid", vld0, 1);
    push(1'b0, 8'h00, 32'h0);
    cyc();
    check("bp_empty", vld0, 0);
    check("bp_stall", stc1, perf(2));

    // flush while in SKID with D arriving
    out_ready = 1'b0;
    push(1'b1, 8'h21, 32'h100);
    cyc();
    push(1'b1, 8'h22, 32'h200);
    cyc();
    check("fl_pre_ready", rdy0, 0);
    flush = 1'b1;
    push(1'b1, 8'h23, 32'h300);
    cyc();
    flush = 1'b0;
    push(1'b0, 8'h00, 32'h0);
    check("fl_valid", vld0, 0);
    check("fl_ctrl", ctl0, BUB);
    check("fl_ready", rdy0, 1);
    check("fl_hold_data", dat0, 32'h100);
    check("fl_clr_data", dat1, 0);
    check("fl_clr_ctrl", ctl1, BUB);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("fl_no_ghost", vld0, 0);
    end
    check("fl_stall", stc1, perf(4));
    check("fl_cnt", flc0, perf(1));

    // stall saturation
    out_ready = 1'b0;
    push(1'b1, 8'h55, 32'h55);
    cyc();
    push(1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 20; i++) cyc();
    check("sat_valid", vld0, 1);
    check("sat_data", dat0, 32'h55);
    check("sat_stall4", stc0, perf(15));
    check("sat_stall16", stc1, perf(24));
    cyc();
    check("sat_nowrap", stc0, perf(15));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
